// File: rtl/vme_bus_arbiter.sv
// Round-robin arbiter: two strobe requesters share one slave bus, watchdog on stalled accesses.
// Strobe to downstream strobe in 2 cycles, done to requester done in 1; extra strobes while busy are dropped.
module vme_bus_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          Clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_Addr,
  input  logic [DW-1:0] a_WrData,
  input  logic          a_RdMem,
  input  logic          a_WrMem,
  output logic [DW-1:0] a_RdData,
  output logic          a_RdDone,
  output logic          a_WrDone,
  output logic          a_RdError,
  output logic          a_WrError,
  output logic          a_Busy,
  input  logic [AW-1:0] b_Addr,
  input  logic [DW-1:0] b_WrData,
  input  logic          b_RdMem,
  input  logic          b_WrMem,
  output logic [DW-1:0] b_RdData,
  output logic          b_RdDone,
  output logic          b_WrDone,
  output logic          b_RdError,
  output logic          b_WrError,
  output logic          b_Busy,
  output logic [AW-1:0] m_Addr,
  output logic [DW-1:0] m_WrData,
  output logic          m_RdMem,
  output logic          m_WrMem,
  input  logic [DW-1:0] m_RdData,
  input  logic          m_RdDone,
  input  logic          m_WrDone,
  input  logic          m_RdError,
  input  logic          m_WrError,
  output logic          timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  logic [1:0]    req_rd, req_wr;
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_wdat [2];

  logic [1:0]    lat_vld_q, lat_wr_q;
  logic [AW-1:0] lat_addr_q [2];
  logic [DW-1:0] lat_wdat_q [2];

  state_t        state_q;
  logic          gnt_q, last_q, kind_wr_q;
  logic [15:0]   wd_q;
  logic          m_rd_q, m_wr_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdat_q;
  logic [1:0]    rd_done_q, wr_done_q, rd_err_q, wr_err_q;
  logic [DW-1:0] rdata_q [2];
  logic          timeout_q;

  logic [1:0]    free;
  logic          gnt_d, done_hit, wd_expired;

  assign req_rd      = {b_RdMem, a_RdMem};
  assign req_wr      = {b_WrMem, a_WrMem};
  assign req_addr[0] = a_Addr;
  assign req_addr[1] = b_Addr;
  assign req_wdat[0] = a_WrData;
  assign req_wdat[1] = b_WrData;

  // The owner's latch frees during its RESP cycle so a strobe there is taken.
  assign free       = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign gnt_d      = (lat_vld_q == 2'b11) ? ~last_q : lat_vld_q[1];
  assign done_hit   = kind_wr_q ? m_WrDone : m_RdDone;
  assign wd_expired = (wd_q == 16'(TIMEOUT - 1));

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_vld_q <= '0;
      lat_wr_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        lat_addr_q[i] <= '0;
        lat_wdat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((!lat_vld_q[i] || free[i]) && (req_rd[i] || req_wr[i])) begin
          lat_vld_q[i]  <= 1'b1;
          lat_wr_q[i]   <= req_wr[i];
          lat_addr_q[i] <= req_addr[i];
          lat_wdat_q[i] <= req_wdat[i];
        end else if (free[i]) begin
          lat_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      kind_wr_q <= 1'b0;
      wd_q      <= '0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdat_q  <= '0;
      rd_done_q <= '0;
      wr_done_q <= '0;
      rd_err_q  <= '0;
      wr_err_q  <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      timeout_q <= 1'b0;
    end else begin
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      rd_done_q <= '0;
      wr_done_q <= '0;
      rd_err_q  <= '0;
      wr_err_q  <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|lat_vld_q) begin
            gnt_q     <= gnt_d;
            last_q    <= gnt_d;
            kind_wr_q <= lat_wr_q[gnt_d];
            m_rd_q    <= ~lat_wr_q[gnt_d];
            m_wr_q    <= lat_wr_q[gnt_d];
            m_addr_q  <= lat_addr_q[gnt_d];
            m_wdat_q  <= lat_wdat_q[gnt_d];
            wd_q      <= '0;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (done_hit || wd_expired) begin
            // A real done on the last watchdog cycle still wins over the timeout.
            state_q   <= S_RESP;
            timeout_q <= ~done_hit;
            if (kind_wr_q) begin
              wr_done_q[gnt_q] <= 1'b1;
              wr_err_q[gnt_q]  <= done_hit ? m_WrError : 1'b1;
            end else begin
              rd_done_q[gnt_q] <= 1'b1;
              rd_err_q[gnt_q]  <= done_hit ? m_RdError : 1'b1;
              rdata_q[gnt_q]   <= done_hit ? m_RdData : '0;
            end
          end else begin
            wd_q    <= wd_q + 16'd1;
            state_q <= S_WAIT;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_RdData  = rdata_q[0];
  assign a_RdDone  = rd_done_q[0];
  assign a_WrDone  = wr_done_q[0];
  assign a_RdError = rd_err_q[0];
  assign a_WrError = wr_err_q[0];
  assign a_Busy    = lat_vld_q[0];
  assign b_RdData  = rdata_q[1];
  assign b_RdDone  = rd_done_q[1];
  assign b_WrDone  = wr_done_q[1];
  assign b_RdError = rd_err_q[1];
  assign b_WrError = wr_err_q[1];
  assign b_Busy    = lat_vld_q[1];
  assign m_Addr    = m_addr_q;
  assign m_WrData  = m_wdat_q;
  assign m_RdMem   = m_rd_q;
  assign m_WrMem   = m_wr_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_vme_bus_arbiter.sv
// Directed bench for vme_bus_arbiter with a small programmable slave (ack delay, error, late-done injection).
module tb_vme_bus_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] a_Addr, b_Addr, m_Addr;
  logic [DW-1:0] a_WrData, b_WrData, m_WrData, a_RdData, b_RdData, m_RdData;
  logic          a_RdMem, a_WrMem, a_RdDone, a_WrDone, a_RdError, a_WrError, a_Busy;
  logic          b_RdMem, b_WrMem, b_RdDone, b_WrDone, b_RdError, b_WrError, b_Busy;
  logic          m_RdMem, m_WrMem, m_RdDone, m_WrDone, m_RdError, m_WrError, timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model: delay 0 acks in the strobe cycle, N>0 acks N cycles later, -1 never acks.
  int          slv_delay;
  int          slv_cnt;
  logic        slv_busy, slv_wr, slv_err, inj_rd, late_done;
  logic [DW-1:0] slv_rdata;
  int          n_mwr = 0, n_awd = 0, excl_viol = 0;

  always #5 Clk = ~Clk;

  vme_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .Clk(Clk), .rst_n(rst_n),
    .a_Addr(a_Addr), .a_WrData(a_WrData), .a_RdMem(a_RdMem), .a_WrMem(a_WrMem),
    .a_RdData(a_RdData), .a_RdDone(a_RdDone), .a_WrDone(a_WrDone),
    .a_RdError(a_RdError), .a_WrError(a_WrError), .a_Busy(a_Busy),
    .b_Addr(b_Addr), .b_WrData(b_WrData), .b_RdMem(b_RdMem), .b_WrMem(b_WrMem),
    .b_RdData(b_RdData), .b_RdDone(b_RdDone), .b_WrDone(b_WrDone),
    .b_RdError(b_RdError), .b_WrError(b_WrError), .b_Busy(b_Busy),
    .m_Addr(m_Addr), .m_WrData(m_WrData), .m_RdMem(m_RdMem), .m_WrMem(m_WrMem),
    .m_RdData(m_RdData), .m_RdDone(m_RdDone), .m_WrDone(m_WrDone),
    .m_RdError(m_RdError), .m_WrError(m_WrError), .timeout_o(timeout_o)
  );

  always @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_busy <= 1'b0;
      slv_cnt  <= 0;
      slv_wr   <= 1'b0;
    end else if (m_RdMem || m_WrMem) begin
      slv_wr   <= m_WrMem;
      slv_busy <= (slv_delay > 0);
      slv_cnt  <= 1;
    end else if (slv_busy) begin
      if (slv_cnt == slv_delay) slv_busy <= 1'b0;
      else slv_cnt <= slv_cnt + 1;
    end
  end

  assign late_done = slv_busy && (slv_delay > 0) && (slv_cnt == slv_delay);
  assign m_RdDone  = ((slv_delay == 0) ? m_RdMem : (late_done && !slv_wr)) || inj_rd;
  assign m_WrDone  = (slv_delay == 0) ? m_WrMem : (late_done && slv_wr);
  assign m_RdError = slv_err && m_RdDone;
  assign m_WrError = slv_err && m_WrDone;
  assign m_RdData  = slv_rdata;

  always @(posedge Clk) begin
    if (m_WrMem) n_mwr <= n_mwr + 1;
    if (a_WrDone) n_awd <= n_awd + 1;
  end

  always @(negedge Clk) if (m_RdMem && m_WrMem) excl_viol <= excl_viol + 1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    a_RdMem = 1'b0; a_WrMem = 1'b0; b_RdMem = 1'b0; b_WrMem = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int w0, d0;

  initial begin
    rst_n = 1'b0;
    clr();
    a_Addr = '0; a_WrData = '0; b_Addr = '0; b_WrData = '0;
    slv_delay = 0; slv_err = 1'b0; inj_rd = 1'b0; slv_rdata = '0;
    repeat (2) tick();
    chk("rst_a_busy", a_Busy, 0);
    chk("rst_b_busy", b_Busy, 0);
    chk("rst_m_rd", m_RdMem, 0);
    chk("rst_m_wr", m_WrMem, 0);
    chk("rst_m_addr", m_Addr, 0);
    chk("rst_a_rdata", a_RdData, 0);
    chk("rst_a_rddone", a_RdDone, 0);
    chk("rst_timeout", timeout_o, 0);
    rst_n = 1'b1;
    tick();

    // Tie after reset: A (write) first, then B (read)
    a_WrMem = 1; a_Addr = 13'h020; a_WrData = 32'h1111_2222;
    b_RdMem = 1; b_Addr = 13'h030; slv_rdata = 32'hCAFE_0001;
    tick(); clr();
    chk("tie1_a_busy", a_Busy, 1);
    chk("tie1_b_busy", b_Busy, 1);
    chk("tie1_pend_mwr", m_WrMem, 0);
    tick();
    chk("tie1_mwr", m_WrMem, 1);
    chk("tie1_mrd0", m_RdMem, 0);
    chk("tie1_maddr_a", m_Addr, 13'h020);
    chk("tie1_mwdat_a", m_WrData, 32'h1111_2222);
    tick();
    chk("tie1_a_wrdone", a_WrDone, 1);
    chk("tie1_a_wrerr", a_WrError, 0);
    chk("tie1_b_rddone0", b_RdDone, 0);
    tick();
    chk("tie1_idle_mrd", m_RdMem, 0);
    chk("tie1_a_free", a_Busy, 0);
    tick();
    chk("tie1_mrd_b", m_RdMem, 1);
    chk("tie1_maddr_b", m_Addr, 13'h030);
    tick();
    chk("tie1_b_rddone", b_RdDone, 1);
    chk("tie1_b_rdata", b_RdData, 32'hCAFE_0001);
    chk("tie1_a_rddone0", a_RdDone, 0);

    // Single read A, slave acks in the strobe cycle
    tick();
    slv_rdata = 32'hDEAD_BEEF; a_RdMem = 1; a_Addr = 13'h010;
    tick(); clr();
    tick();
    chk("rdA_mrd", m_RdMem, 1);
    chk("rdA_maddr", m_Addr, 13'h010);
    tick();
    chk("rdA_done", a_RdDone, 1);
    chk("rdA_data", a_RdData, 32'hDEAD_BEEF);
    chk("rdA_err", a_RdError, 0);
    tick();
    chk("rdA_done_pulse", a_RdDone, 0);
    chk("rdA_data_hold", a_RdData, 32'hDEAD_BEEF);
    chk("rdA_b_hold", b_RdData, 32'hCAFE_0001);

    // Repeat tie: last grant was A so B wins; slave flags errors
    slv_err = 1; slv_rdata = 32'h0000_0077;
    a_RdMem = 1; a_Addr = 13'h040;
    b_WrMem = 1; b_Addr = 13'h050; b_WrData = 32'hA5A5_A5A5;
    tick(); clr();
    tick();
    chk("tie2_mwr_b", m_WrMem, 1);
    chk("tie2_maddr_b", m_Addr, 13'h050);
    chk("tie2_mwdat_b", m_WrData, 32'hA5A5_A5A5);
    tick();
    chk("tie2_b_wrdone", b_WrDone, 1);
    chk("tie2_b_wrerr", b_WrError, 1);
    tick(); tick();
    chk("tie2_mrd_a", m_RdMem, 1);
    chk("tie2_maddr_a", m_Addr, 13'h040);
    tick();
    chk("tie2_a_rddone", a_RdDone, 1);
    chk("tie2_a_rderr", a_RdError, 1);
    chk("tie2_a_rdata", a_RdData, 32'h0000_0077);
    slv_err = 0;

    // B write, slave delays WrDone by 5 cycles
    tick();
    slv_delay = 5;
    b_WrMem = 1; b_Addr = 13'h100; b_WrData = 32'h1234_5678;
    tick(); clr();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("dly_maddr", m_Addr, 13'h100);
      chk("dly_mwdat", m_WrData, 32'h1234_5678);
      chk("dly_mwr", m_WrMem, (i == 0));
      chk("dly_mwrdone", m_WrDone, (i == 5));
      chk("dly_bdone0", b_WrDone, 0);
      tick();
    end
    chk("dly_b_wrdone", b_WrDone, 1);
    chk("dly_b_wrerr", b_WrError, 0);
    tick();
    chk("dly_b_free", b_Busy, 0);

    // Slave never acks: watchdog after 8 cycles
    slv_delay = -1; a_RdMem = 1; a_Addr = 13'h200;
    tick(); clr();
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("wd_done0", a_RdDone, 0);
      chk("wd_to0", timeout_o, 0);
      chk("wd_maddr", m_Addr, 13'h200);
      tick();
    end
    chk("wd_done", a_RdDone, 1);
    chk("wd_err", a_RdError, 1);
    chk("wd_rdata0", a_RdData, 0);
    chk("wd_timeout", timeout_o, 1);
    tick();
    inj_rd = 1; slv_rdata = 32'h0000_0BAD;
    chk("wd_to_pulse", timeout_o, 0);
    tick();
    inj_rd = 0;
    chk("wd_late_done", a_RdDone, 0);
    chk("wd_late_data", a_RdData, 0);
    chk("wd_late_busy", a_Busy, 0);
    chk("wd_late_mrd", m_RdMem, 0);
    slv_delay = 0; slv_rdata = 32'h0000_600D; a_RdMem = 1; a_Addr = 13'h204;
    tick(); clr();
    tick();
    chk("wd_next_mrd", m_RdMem, 1);
    chk("wd_next_maddr", m_Addr, 13'h204);
    tick();
    chk("wd_next_done", a_RdDone, 1);
    chk("wd_next_err", a_RdError, 0);
    chk("wd_next_data", a_RdData, 32'h0000_600D);

    // Strobe while busy is dropped; strobe in RESP cycle is accepted
    tick();
    slv_delay = 3; w0 = n_mwr; d0 = n_awd;
    a_WrMem = 1; a_Addr = 13'h300; a_WrData = 32'h1;
    tick(); clr();
    tick();
    a_WrMem = 1; a_Addr = 13'h304; a_WrData = 32'h2;
    chk("viol_busy", a_Busy, 1);
    tick(); clr();
    tick(); tick(); tick();
    chk("viol_wrdone", a_WrDone, 1);
    a_RdMem = 1; a_Addr = 13'h308;
    tick(); clr();
    chk("resp_acc_busy", a_Busy, 1);
    chk("resp_acc_idle", m_RdMem, 0);
    tick();
    chk("resp_acc_mrd", m_RdMem, 1);
    chk("resp_acc_maddr", m_Addr, 13'h308);
    repeat (4) tick();
    chk("resp_acc_done", a_RdDone, 1);
    tick();
    chk("viol_one_mwr", n_mwr - w0, 1);
    chk("viol_one_done", n_awd - d0, 1);

    // Reset during WAIT
    slv_delay = -1; a_RdMem = 1; a_Addr = 13'h400;
    tick(); clr();
    tick(); tick(); tick();
    chk("rstw_maddr", m_Addr, 13'h400);
    chk("rstw_busy", a_Busy, 1);
    rst_n = 0;
    #1;
    chk("rstw_a_busy0", a_Busy, 0);
    chk("rstw_maddr0", m_Addr, 0);
    chk("rstw_mrd0", m_RdMem, 0);
    chk("rstw_rdata0", a_RdData, 0);
    tick(); tick();
    rst_n = 1; slv_delay = 0;
    tick();
    chk("rstw_no_resp", a_RdDone, 0);
    chk("rstw_no_issue", m_RdMem, 0);
    slv_rdata = 32'h0000_0055;
    a_RdMem = 1; a_Addr = 13'h500; b_RdMem = 1; b_Addr = 13'h600;
    tick(); clr();
    tick();
    chk("rstw_a_first", m_Addr, 13'h500);
    chk("rstw_a_mrd", m_RdMem, 1);
    tick();
    chk("rstw_a_done", a_RdDone, 1);
    tick(); tick();
    chk("rstw_b_second", m_Addr, 13'h600);
    tick();
    chk("rstw_b_done", b_RdDone, 1);
    chk("rstw_b_data", b_RdData, 32'h0000_0055);

    chk("excl_strobes", excl_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
